alu_share_arbiter: RTL

//   Shares the single combinational ALU between NREQ requesters (e.g. execute stage, address generator).

---
 rtl/alu_share_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Lets NREQ pipeline units share one combinational ALU. A round-robin
//   arbiter picks one pending request in IDLE, registers its operands toward
//   the ALU, gives the ALU a full EXEC cycle to settle, registers the result
//   and presents it to the owning requester until that requester accepts it.
//   Unsupported opcode/funct pairs skip EXEC and answer with an error flag.
module alu_share_arbiter #(
   parameter int NREQ = 2,
   parameter int PTRW = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_in1,
   input  logic [NREQ*32-1:0]   req_in2,
   input  logic [NREQ*6-1:0]    req_opcode,
   input  logic [NREQ*6-1:0]    req_funct,
   output logic [31:0]          alu_in1,
   output logic [31:0]          alu_in2,
   output logic [5:0]           alu_opcode,
   output logic [5:0]           alu_funct,
   input  logic [31:0]          alu_out,
   input  logic                 alu_zero,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [31:0]          resp_data,
   output logic                 resp_zero,
   output logic                 resp_err
);

   // Opcode / funct encodings understood by the shared ALU
   localparam logic [5:0] OPCODE_RTYPE = 6'h00;
   localparam logic [5:0] OPCODE_ADDI  = 6'h08;
   localparam logic [5:0] OPCODE_ADDIU = 6'h09;
   localparam logic [5:0] OPCODE_LW    = 6'h23;
   localparam logic [5:0] OPCODE_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_ADD    = 6'h20;
   localparam logic [5:0] FUNCT_ADDU   = 6'h21;
   localparam logic [5:0] FUNCT_SUB    = 6'h22;
   localparam logic [5:0] FUNCT_SUBU   = 6'h23;
   localparam logic [5:0] FUNCT_SLT    = 6'h2A;
   localparam logic [5:0] FUNCT_SLTU   = 6'h2B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic [PTRW-1:0]   rr_ptr;
   logic [PTRW-1:0]   owner;
   logic [PTRW-1:0]   winner;
   logic              found;
   logic [31:0]       sel_in1;
   logic [31:0]       sel_in2;
   logic [5:0]        sel_opcode;
   logic [5:0]        sel_funct;

   // (base + step) modulo NREQ, used for the rotating search and pointer advance
   function automatic logic [PTRW-1:0] wrap_add(input logic [PTRW-1:0] base, input int step);
      int sum;
      sum = (int'(base) + step) % NREQ;
      return PTRW'(sum);
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [PTRW-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // True when the ALU implements this opcode/funct combination
   function automatic logic is_supported(input logic [5:0] opcode, input logic [5:0] funct);
      logic ok;
      ok = 1'b0;
      case (opcode)
         OPCODE_RTYPE: begin
            case (funct)
               FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB,
               FUNCT_SUBU, FUNCT_SLT, FUNCT_SLTU: ok = 1'b1;
               default:                           ok = 1'b0;
            endcase
         end
         OPCODE_ADDI, OPCODE_ADDIU, OPCODE_LW, OPCODE_SW: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Round-robin search: first valid requester at or after rr_ptr
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[wrap_add(rr_ptr, k)]) begin
            found  = 1'b1;
            winner = wrap_add(rr_ptr, k);
         end
      end
   end

   // Operand mux for the current winner
   always_comb begin
      sel_in1    = '0;
      sel_in2    = '0;
      sel_opcode = '0;
      sel_funct  = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (winner == PTRW'(k)) begin
            sel_in1    = req_in1[32*k +: 32];
            sel_in2    = req_in2[32*k +: 32];
            sel_opcode = req_opcode[6*k +: 6];
            sel_funct  = req_funct[6*k +: 6];
         end
      end
   end

   // Accept strobe: only in IDLE, and held low while reset is asserted
   always_comb begin
      req_ready = '0;
      if (!reset && (state == IDLE) && found) begin
         req_ready = onehot(winner);
      end
   end

   // Control FSM plus the registered ALU operands and response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         alu_in1    <= '0;
         alu_in2    <= '0;
         alu_opcode <= '0;
         alu_funct  <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
         resp_zero  <= 1'b0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  alu_in1    <= sel_in1;
                  alu_in2    <= sel_in2;
                  alu_opcode <= sel_opcode;
                  alu_funct  <= sel_funct;
                  owner      <= winner;
                  if (is_supported(sel_opcode, sel_funct)) begin
                     state <= EXEC;
                  end else begin
                     // Nothing for the ALU to do: answer with an error right away
                     resp_err   <= 1'b1;
                     resp_data  <= '0;
                     resp_zero  <= 1'b0;
                     resp_valid <= onehot(winner);
                     state      <= RESP;
                  end
               end
            end
            EXEC: begin
               // ALU inputs have been stable for a whole cycle; capture its result
               resp_data  <= alu_out;
               resp_zero  <= alu_zero;
               resp_err   <= 1'b0;
               resp_valid <= onehot(owner);
               state      <= RESP;
            end
            RESP: begin
               // Only the owner's accept matters; others are ignored
               if (resp_ready[owner]) begin
                  resp_valid <= '0;
                  rr_ptr     <= wrap_add(owner, 1);
                  state      <= IDLE;
               end
            end
            default: begin
               resp_valid <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
